// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage with a 2-entry skid buffer, flush and stall support.
// Optional statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_skid #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 16,
  parameter int FLUSH_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_next, skid_ctrl, skid_ctrl_next;
  logic [DATA_W-1:0] main_data, main_data_next, skid_data, skid_data_next;
  logic              in_fire, out_fire;

  assign out_valid = (state != EMPTY);
  assign in_ready  = !Reset && (state != FULL);
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_next     = state;
    main_ctrl_next = main_ctrl;
    main_data_next = main_data;
    skid_ctrl_next = skid_ctrl;
    skid_data_next = skid_data;
    if (Flush) begin
      state_next     = EMPTY;
      main_ctrl_next = '0;
      skid_ctrl_next = '0;
      if (FLUSH_DATA != 0) begin
        main_data_next = '0;
        skid_data_next = '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_ctrl_next = in_ctrl;
            main_data_next = in_data;
            state_next     = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_ctrl_next = in_ctrl;
            main_data_next = in_data;
          end else if (in_fire) begin
            skid_ctrl_next = in_ctrl;
            skid_data_next = in_data;
            state_next     = FULL;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          // The skid entry is always older than anything upstream, so it moves up first.
          if (out_fire) begin
            main_ctrl_next = skid_ctrl;
            main_data_next = skid_data;
            state_next     = BUSY;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_next;
      main_ctrl <= main_ctrl_next;
      main_data <= main_data_next;
      skid_ctrl <= skid_ctrl_next;
      skid_data <= skid_data_next;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid && !out_ready && !Flush && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + 1'b1;
      if (Flush && (state != EMPTY) && (flush_q != {CNT_W{1'b1}}))
        flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, counter sequence and
// a randomised queue scoreboard run against a FLUSH_DATA=1 and a FLUSH_DATA=0 instance.
module tb_pipe_stage_skid;

`ifdef PIPE_STAGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [3:0] CNT_MAX = 4'hF;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1, Flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] in_ctrl = '0;
  logic [31:0] in_data = '0;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [15:0] out_ctrl_a, out_ctrl_b;
  logic [31:0] out_data_a, out_data_b;
  logic [3:0]  stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] c;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];
  logic [3:0] m_stall = '0;
  logic [3:0] m_flush = '0;

  typedef struct {
    string       name;
    logic        rst, fl, iv, ordy;
    logic [15:0] c;
    logic [31:0] d;
    logic        ov, ir;
    logic [15:0] oc;
    logic [31:0] od, odb;
  } vec_t;
  vec_t vecs[$];

  always #5 Clk = ~Clk;

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .FLUSH_DATA(1), .CNT_W(4)) dut_a (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_ctrl(out_ctrl_a), .out_data(out_data_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .FLUSH_DATA(0), .CNT_W(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_ctrl(out_ctrl_b), .out_data(out_data_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string name, input logic rst, fl, iv, ordy,
                              input logic [15:0] c, input logic [31:0] d,
                              input logic ov, ir, input logic [15:0] oc,
                              input logic [31:0] od, odb);
    vec_t v;
    v.name = name; v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.c = c; v.d = d;
    v.ov = ov; v.ir = ir; v.oc = oc; v.od = od; v.odb = odb;
    return v;
  endfunction

  // Drives one cycle of inputs, checks the current outputs against the queue model,
  // then advances the model and the clock.
  task automatic applyStimulus(input logic rst, fl, iv, ordy,
                               input logic [15:0] c, input logic [31:0] d);
    logic m_ir, m_ov;
    Reset = rst; Flush = fl; in_valid = iv; out_ready = ordy; in_ctrl = c; in_data = d;
    #1;
    m_ir = !rst && (q.size() < 2);
    m_ov = (q.size() != 0);
    cmp("in_ready_a", 64'(in_ready_a), 64'(m_ir));
    cmp("in_ready_b", 64'(in_ready_b), 64'(m_ir));
    cmp("out_valid_a", 64'(out_valid_a), 64'(m_ov));
    cmp("out_valid_b", 64'(out_valid_b), 64'(m_ov));
    if (m_ov) begin
      cmp("head_ctrl_a", 64'(out_ctrl_a), 64'(q[0].c));
      cmp("head_data_a", 64'(out_data_a), 64'(q[0].d));
      cmp("head_ctrl_b", 64'(out_ctrl_b), 64'(q[0].c));
      cmp("head_data_b", 64'(out_data_b), 64'(q[0].d));
    end
    cmp("stall_cnt_a", 64'(stall_cnt_a), 64'(m_stall));
    cmp("flush_cnt_a", 64'(flush_cnt_a), 64'(m_flush));
    cmp("stall_cnt_b", 64'(stall_cnt_b), 64'(m_stall));
    cmp("flush_cnt_b", 64'(flush_cnt_b), 64'(m_flush));
    if (rst) begin
      q.delete();
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (STATS && m_ov && !ordy && !fl && m_stall != CNT_MAX) m_stall++;
      if (STATS && fl && m_ov && m_flush != CNT_MAX) m_flush++;
      if (m_ov && ordy) void'(q.pop_front());
      if (fl) q.delete();
      else if (iv && m_ir) q.push_back('{c: c, d: d});
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v);
    cmp({v.name, ".out_valid"}, 64'(out_valid_a), 64'(v.ov));
    cmp({v.name, ".in_ready"}, 64'(in_ready_a), 64'(v.ir));
    cmp({v.name, ".out_ctrl"}, 64'(out_ctrl_a), 64'(v.oc));
    cmp({v.name, ".out_data"}, 64'(out_data_a), 64'(v.od));
    cmp({v.name, ".out_ctrl_b"}, 64'(out_ctrl_b), 64'(v.oc));
    cmp({v.name, ".out_data_b"}, 64'(out_data_b), 64'(v.odb));
  endtask

  initial begin
    //                name     rst fl iv rdy ctrl      data       ov ir oc        od         odb
    vecs.push_back(mk("rst0",  1, 0, 0, 0, 16'h0000, 32'h0,     0, 0, 16'h0000, 32'h0,     32'h0));
    vecs.push_back(mk("rst1",  1, 0, 1, 1, 16'h0063, 32'h63,    0, 0, 16'h0000, 32'h0,     32'h0));
    vecs.push_back(mk("seq1",  0, 0, 1, 1, 16'h0011, 32'h1,     1, 1, 16'h0011, 32'h1,     32'h1));
    vecs.push_back(mk("seq2",  0, 0, 1, 1, 16'h0012, 32'h2,     1, 1, 16'h0012, 32'h2,     32'h2));
    vecs.push_back(mk("seq3",  0, 0, 1, 1, 16'h0013, 32'h3,     1, 1, 16'h0013, 32'h3,     32'h3));
    vecs.push_back(mk("seq4",  0, 0, 1, 1, 16'h0014, 32'h4,     1, 1, 16'h0014, 32'h4,     32'h4));
    vecs.push_back(mk("drain", 0, 0, 0, 1, 16'h0000, 32'h0,     0, 1, 16'h0014, 32'h4,     32'h4));
    vecs.push_back(mk("pushA", 0, 0, 1, 0, 16'h00AA, 32'hA,     1, 1, 16'h00AA, 32'hA,     32'hA));
    vecs.push_back(mk("pushB", 0, 0, 1, 0, 16'h00BB, 32'hB,     1, 0, 16'h00AA, 32'hA,     32'hA));
    vecs.push_back(mk("holdC", 0, 0, 1, 0, 16'h00CC, 32'hC,     1, 0, 16'h00AA, 32'hA,     32'hA));
    vecs.push_back(mk("popA",  0, 0, 0, 1, 16'h0000, 32'h0,     1, 1, 16'h00BB, 32'hB,     32'hB));
    vecs.push_back(mk("popB",  0, 0, 0, 1, 16'h0000, 32'h0,     0, 1, 16'h00BB, 32'hB,     32'hB));
    vecs.push_back(mk("fillF1",0, 0, 1, 0, 16'hFFFF, 32'h100,   1, 1, 16'hFFFF, 32'h100,   32'h100));
    vecs.push_back(mk("fillF2",0, 0, 1, 0, 16'hFFFF, 32'h101,   1, 0, 16'hFFFF, 32'h100,   32'h100));
    vecs.push_back(mk("flush", 0, 1, 1, 0, 16'h1234, 32'h999,   0, 1, 16'h0000, 32'h0,     32'h100));
    vecs.push_back(mk("pflush",0, 0, 0, 0, 16'h0000, 32'h0,     0, 1, 16'h0000, 32'h0,     32'h100));
    vecs.push_back(mk("fillR1",0, 0, 1, 0, 16'h0005, 32'h500,   1, 1, 16'h0005, 32'h500,   32'h500));
    vecs.push_back(mk("fillR2",0, 0, 1, 0, 16'h0006, 32'h600,   1, 0, 16'h0005, 32'h500,   32'h500));
    vecs.push_back(mk("rstMid",1, 0, 1, 0, 16'h0007, 32'h700,   0, 0, 16'h0000, 32'h0,     32'h0));
    vecs.push_back(mk("prst",  0, 0, 0, 1, 16'h0000, 32'h0,     0, 1, 16'h0000, 32'h0,     32'h0));

    repeat (2) @(posedge Clk);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].c, vecs[i].d);
      checkOutput(vecs[i]);
    end

    // Counter saturation and flush accounting, starting from EMPTY with cleared counters.
    applyStimulus(0, 0, 1, 0, 16'h0042, 32'h42);
    repeat (20) applyStimulus(0, 0, 0, 0, 16'h0, 32'h0);
    cmp("stall_sat", 64'(stall_cnt_a), STATS ? 64'hF : 64'h0);
    applyStimulus(0, 1, 0, 0, 16'h0, 32'h0);
    cmp("flush_busy", 64'(flush_cnt_a), STATS ? 64'h1 : 64'h0);
    applyStimulus(0, 1, 0, 0, 16'h0, 32'h0);
    cmp("flush_empty", 64'(flush_cnt_a), STATS ? 64'h1 : 64'h0);

    for (int n = 0; n < 10000; n++) begin
      applyStimulus($urandom_range(0, 999) == 0,
                    $urandom_range(0, 63) == 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) != 0,
                    16'($urandom), $urandom);
    end
    repeat (4) applyStimulus(0, 0, 0, 1, 16'h0, 32'h0);
    cmp("drained", 64'(out_valid_a), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
